// File: rtl/id_stage_pkg.sv
// Shared encodings for the MIPS16-subset decode stage: opcodes, ALU ops,
// rwe codes and the stall scheduler states.
package id_stage_pkg;

  localparam logic [4:0] INSTR_OPCODE5_B      = 5'b00010;
  localparam logic [4:0] INSTR_OPCODE5_SHIFT  = 5'b00110;
  localparam logic [4:0] INSTR_OPCODE5_ADDIU8 = 5'b01001;
  localparam logic [4:0] INSTR_OPCODE5_LI     = 5'b01101;
  localparam logic [4:0] INSTR_OPCODE5_LW     = 5'b10011;
  localparam logic [4:0] INSTR_OPCODE5_SW     = 5'b11011;

  localparam logic [1:0] INSTR_OPCODE_LOW2_SLL = 2'b00;

  localparam logic [7:0] ALU_OPCODE_ADD = 8'h00;
  localparam logic [7:0] ALU_OPCODE_SLL = 8'h01;

  localparam logic [1:0] RWE_IDLE      = 2'd0;
  localparam logic [1:0] RWE_READ_MEM  = 2'd1;
  localparam logic [1:0] RWE_WRITE_MEM = 2'd2;
  localparam logic [1:0] RWE_WRITE_REG = 2'd3;

  // Default-width invalid register; parametrised modules use all-ones of REG_AW.
  localparam logic [3:0] REG_INVALID = 4'hF;

  typedef enum logic {
    SCHED_RUN   = 1'b0,
    SCHED_STALL = 1'b1
  } sched_e;

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand forwarding selector with load-use hazard flag.
// ID_BYPASS_EN selects the forwarding network; otherwise any pending write stalls.
module id_fwd_mux
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int FWD_N  = 2
) (
  input  logic [REG_AW-1:0]       src_i,
  input  logic [DATA_W-1:0]       rf_data_i,
  input  logic [2*FWD_N-1:0]      fwd_rwe_i,
  input  logic [REG_AW*FWD_N-1:0] fwd_reg_i,
  input  logic [DATA_W*FWD_N-1:0] fwd_result_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    hazard_o
);

  localparam logic [REG_AW-1:0] REG_INV = '1;

  logic [FWD_N-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < FWD_N; i++) begin
      hit[i] = (src_i != REG_INV) && (fwd_reg_i[i*REG_AW +: REG_AW] == src_i);
    end
  end

`ifdef ID_BYPASS_EN
  // Walk oldest to nearest so the nearest matching stage wins.
  always_comb begin
    data_o   = rf_data_i;
    hazard_o = 1'b0;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (hit[i] && fwd_rwe_i[2*i +: 2] == RWE_WRITE_REG) data_o = fwd_result_i[i*DATA_W +: DATA_W];
      if (hit[i] && fwd_rwe_i[2*i +: 2] == RWE_READ_MEM) hazard_o = 1'b1;
    end
  end
`else
  logic unused_fwd_result;
  assign unused_fwd_result = ^fwd_result_i;

  always_comb begin
    data_o   = rf_data_i;
    hazard_o = 1'b0;
    for (int i = 0; i < FWD_N; i++) begin
      if (hit[i] && (fwd_rwe_i[2*i +: 2] == RWE_WRITE_REG ||
                     fwd_rwe_i[2*i +: 2] == RWE_READ_MEM)) hazard_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/id_stage.sv
// Registered MIPS16-subset decode stage with valid/ready output register,
// load-use interlock and flush. ID_BYPASS_EN enables operand forwarding.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int FWD_N  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_W-1:0]       in_addr_i,
  input  logic [15:0]             in_instr_i,
  output logic [REG_AW-1:0]       rf_raddr1_o,
  output logic [REG_AW-1:0]       rf_raddr2_o,
  input  logic [DATA_W-1:0]       rf_rdata1_i,
  input  logic [DATA_W-1:0]       rf_rdata2_i,
  input  logic [2*FWD_N-1:0]      fwd_rwe_i,
  input  logic [REG_AW*FWD_N-1:0] fwd_reg_i,
  input  logic [DATA_W*FWD_N-1:0] fwd_result_i,
  input  logic                    flush_i,
  input  logic                    ex_ready_i,
  output logic                    out_valid_o,
  output logic [DATA_W-1:0]       out_addr_o,
  output logic [15:0]             out_instr_o,
  output logic [7:0]              out_alu_opcode_o,
  output logic [DATA_W-1:0]       out_op1_o,
  output logic [DATA_W-1:0]       out_op2_o,
  output logic [REG_AW-1:0]       out_wreg_addr_o,
  output logic [DATA_W-1:0]       out_mem_data_o,
  output logic [1:0]              out_rwe_o,
  output logic                    out_branch_o,
  output logic [DATA_W-1:0]       out_new_pc_o
);

  localparam logic [REG_AW-1:0] REG_INV = '1;

  sched_e state_q, state_d;
  logic valid_q, valid_d, accept, hazard, haz1, haz2;
  logic [4:0] opc;
  logic [REG_AW-1:0] rx, ry, src1, src2;
  logic [DATA_W-1:0] opa, opb;
  logic signed [7:0] imm8_s;
  logic signed [4:0] imm5_s;
  logic signed [10:0] imm11_s;

  logic [7:0] alu_d, alu_q;
  logic [DATA_W-1:0] op1_d, op1_q, op2_d, op2_q, mem_d, mem_q, pc_d, pc_q, addr_q;
  logic [REG_AW-1:0] wreg_d, wreg_q;
  logic [1:0] rwe_d, rwe_q;
  logic branch_d, branch_q;
  logic [15:0] instr_q;

  assign opc     = in_instr_i[15:11];
  assign rx      = REG_AW'(in_instr_i[10:8]);
  assign ry      = REG_AW'(in_instr_i[7:5]);
  assign imm8_s  = in_instr_i[7:0];
  assign imm5_s  = in_instr_i[4:0];
  assign imm11_s = in_instr_i[10:0];

  // Unused sources read as REG_INV so they never raise a hazard.
  always_comb begin
    src1 = REG_INV;
    src2 = REG_INV;
    case (opc)
      INSTR_OPCODE5_ADDIU8, INSTR_OPCODE5_LW: src1 = rx;
      INSTR_OPCODE5_SW: begin
        src1 = rx;
        src2 = ry;
      end
      INSTR_OPCODE5_SHIFT: if (in_instr_i[1:0] == INSTR_OPCODE_LOW2_SLL) src1 = ry;
      default: ;
    endcase
  end

  assign rf_raddr1_o = src1;
  assign rf_raddr2_o = src2;

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N)) u_fwd1 (
    .src_i(src1), .rf_data_i(rf_rdata1_i), .fwd_rwe_i(fwd_rwe_i), .fwd_reg_i(fwd_reg_i),
    .fwd_result_i(fwd_result_i), .data_o(opa), .hazard_o(haz1));

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N)) u_fwd2 (
    .src_i(src2), .rf_data_i(rf_rdata2_i), .fwd_rwe_i(fwd_rwe_i), .fwd_reg_i(fwd_reg_i),
    .fwd_result_i(fwd_result_i), .data_o(opb), .hazard_o(haz2));

  assign hazard = haz1 | haz2;

  always_comb begin
    alu_d    = ALU_OPCODE_ADD;
    op1_d    = '0;
    op2_d    = '0;
    wreg_d   = REG_INV;
    mem_d    = '0;
    rwe_d    = RWE_IDLE;
    branch_d = 1'b0;
    pc_d     = '0;
    case (opc)
      INSTR_OPCODE5_ADDIU8: begin
        op1_d  = opa;
        op2_d  = DATA_W'(imm8_s);
        wreg_d = rx;
        rwe_d  = RWE_WRITE_REG;
      end
      INSTR_OPCODE5_LI: begin
        op1_d  = DATA_W'(in_instr_i[7:0]);
        wreg_d = rx;
        rwe_d  = RWE_WRITE_REG;
      end
      INSTR_OPCODE5_SHIFT: if (in_instr_i[1:0] == INSTR_OPCODE_LOW2_SLL) begin
        alu_d  = ALU_OPCODE_SLL;
        op1_d  = opa;
        op2_d  = (in_instr_i[4:2] == 3'd0) ? DATA_W'(8) : DATA_W'(in_instr_i[4:2]);
        wreg_d = rx;
        rwe_d  = RWE_WRITE_REG;
      end
      INSTR_OPCODE5_LW: begin
        op1_d  = opa;
        op2_d  = DATA_W'(imm5_s);
        wreg_d = ry;
        rwe_d  = RWE_READ_MEM;
      end
      INSTR_OPCODE5_SW: begin
        op1_d = opa;
        op2_d = DATA_W'(imm5_s);
        mem_d = opb;
        rwe_d = RWE_WRITE_MEM;
      end
      INSTR_OPCODE5_B: begin
        branch_d = 1'b1;
        pc_d     = in_addr_i + DATA_W'(imm11_s);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    case (state_q)
      SCHED_RUN:   if (in_valid_i && hazard) state_d = SCHED_STALL;
      SCHED_STALL: if (!(in_valid_i && hazard)) state_d = SCHED_RUN;
    endcase
    in_ready_o = !flush_i && !hazard && (ex_ready_i || !valid_q);
    accept     = in_valid_i && in_ready_o;
    if (accept) valid_d = 1'b1;
    else if (ex_ready_i) valid_d = 1'b0;
    if (flush_i) begin
      state_d = SCHED_RUN;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SCHED_RUN;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      instr_q  <= '0;
      alu_q    <= ALU_OPCODE_ADD;
      op1_q    <= '0;
      op2_q    <= '0;
      wreg_q   <= REG_INV;
      mem_q    <= '0;
      rwe_q    <= RWE_IDLE;
      branch_q <= 1'b0;
      pc_q     <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (accept) begin
        addr_q   <= in_addr_i;
        instr_q  <= in_instr_i;
        alu_q    <= alu_d;
        op1_q    <= op1_d;
        op2_q    <= op2_d;
        wreg_q   <= wreg_d;
        mem_q    <= mem_d;
        rwe_q    <= rwe_d;
        branch_q <= branch_d;
        pc_q     <= pc_d;
      end
    end
  end

  assign out_valid_o      = valid_q;
  assign out_addr_o       = addr_q;
  assign out_instr_o      = instr_q;
  assign out_alu_opcode_o = alu_q;
  assign out_op1_o        = op1_q;
  assign out_op2_o        = op2_q;
  assign out_wreg_addr_o  = wreg_q;
  assign out_mem_data_o   = mem_q;
  assign out_rwe_o        = rwe_q;
  assign out_branch_o     = branch_q;
  assign out_new_pc_o     = pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Randomized and directed check of id_stage against an instruction-level model.
// Model follows ID_BYPASS_EN the same way the build does.
module tb_id_stage;

`ifdef ID_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [7:0]  alu;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  wreg;
    logic [15:0] mem;
    logic [1:0]  rwe;
    logic        br;
    logic [15:0] pc;
  } out_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, ex_ready = 1'b1;
  logic [15:0] in_addr = '0, in_instr = '0, rd1 = '0, rd2 = '0;
  logic [3:0] raddr1, raddr2;
  logic [1:0] frwe [2];
  logic [3:0] freg [2];
  logic [15:0] fres [2];
  logic [3:0] fwd_rwe;
  logic [7:0] fwd_reg;
  logic [31:0] fwd_result;
  logic out_valid, out_branch;
  logic [15:0] out_addr, out_instr, out_op1, out_op2, out_mem_data, out_new_pc;
  logic [7:0] out_alu_opcode;
  logic [3:0] out_wreg_addr;
  logic [1:0] out_rwe;

  int n_chk = 0, n_fail = 0;
  out_t exp_o;
  logic exp_valid;

  assign fwd_rwe    = {frwe[1], frwe[0]};
  assign fwd_reg    = {freg[1], freg[0]};
  assign fwd_result = {fres[1], fres[0]};

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_addr_i(in_addr), .in_instr_i(in_instr), .rf_raddr1_o(raddr1), .rf_raddr2_o(raddr2),
    .rf_rdata1_i(rd1), .rf_rdata2_i(rd2), .fwd_rwe_i(fwd_rwe), .fwd_reg_i(fwd_reg),
    .fwd_result_i(fwd_result), .flush_i(flush), .ex_ready_i(ex_ready),
    .out_valid_o(out_valid), .out_addr_o(out_addr), .out_instr_o(out_instr),
    .out_alu_opcode_o(out_alu_opcode), .out_op1_o(out_op1), .out_op2_o(out_op2),
    .out_wreg_addr_o(out_wreg_addr), .out_mem_data_o(out_mem_data), .out_rwe_o(out_rwe),
    .out_branch_o(out_branch), .out_new_pc_o(out_new_pc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register value seen by a source: nearest WRITE_REG producer if bypassing, else the file.
  function automatic logic [15:0] m_operand(input logic [3:0] src, input logic [15:0] rf);
    for (int i = 0; i < 2; i++)
      if (BYPASS && src != 4'hF && freg[i] == src && frwe[i] == 2'd3) return fres[i];
    return rf;
  endfunction

  function automatic bit m_hazard(input logic [3:0] src);
    for (int i = 0; i < 2; i++)
      if (src != 4'hF && freg[i] == src && (frwe[i] == 2'd1 || (!BYPASS && frwe[i] == 2'd3)))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_decode(input logic [15:0] ins, input logic [15:0] addr,
                          output out_t o, output logic [3:0] s1, output logic [3:0] s2);
    logic [3:0] rx, ry, sa;
    rx = {1'b0, ins[10:8]};
    ry = {1'b0, ins[7:5]};
    sa = (ins[4:2] == 3'd0) ? 4'd8 : {1'b0, ins[4:2]};
    o = '0;
    o.addr = addr;
    o.instr = ins;
    o.wreg = 4'hF;
    s1 = 4'hF;
    s2 = 4'hF;
    case (ins[15:11])
      5'd9:  begin s1 = rx; o.op1 = m_operand(rx, rd1); o.op2 = 16'($signed(ins[7:0]));
                   o.wreg = rx; o.rwe = 2'd3; end
      5'd13: begin o.op1 = {8'h00, ins[7:0]}; o.wreg = rx; o.rwe = 2'd3; end
      5'd6:  if (ins[1:0] == 2'b00) begin
               s1 = ry; o.op1 = m_operand(ry, rd1); o.op2 = {12'h000, sa};
               o.alu = 8'h01; o.wreg = rx; o.rwe = 2'd3;
             end
      5'd19: begin s1 = rx; o.op1 = m_operand(rx, rd1); o.op2 = 16'($signed(ins[4:0]));
                   o.wreg = ry; o.rwe = 2'd1; end
      5'd27: begin s1 = rx; s2 = ry; o.op1 = m_operand(rx, rd1); o.op2 = 16'($signed(ins[4:0]));
                   o.mem = m_operand(ry, rd2); o.rwe = 2'd2; end
      5'd2:  begin o.br = 1'b1; o.pc = addr + 16'($signed(ins[10:0])); end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      chk("out_addr", out_addr, exp_o.addr);
      chk("out_instr", out_instr, exp_o.instr);
      chk("out_alu_opcode", out_alu_opcode, exp_o.alu);
      chk("out_op1", out_op1, exp_o.op1);
      chk("out_op2", out_op2, exp_o.op2);
      chk("out_wreg_addr", out_wreg_addr, exp_o.wreg);
      chk("out_mem_data", out_mem_data, exp_o.mem);
      chk("out_rwe", out_rwe, exp_o.rwe);
      chk("out_branch", out_branch, exp_o.br);
      chk("out_new_pc", out_new_pc, exp_o.pc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_branch"}, out_branch, 0);
    chk({tag, "_new_pc"}, out_new_pc, 0);
    chk({tag, "_op1"}, out_op1, 0);
    chk({tag, "_op2"}, out_op2, 0);
    chk({tag, "_mem_data"}, out_mem_data, 0);
    chk({tag, "_alu"}, out_alu_opcode, 8'h00);
    chk({tag, "_wreg"}, out_wreg_addr, 4'hF);
    chk({tag, "_rwe"}, out_rwe, 2'd0);
    chk({tag, "_addr"}, out_addr, 0);
    chk({tag, "_instr"}, out_instr, 0);
  endtask

  task automatic clear_fwd();
    for (int i = 0; i < 2; i++) begin
      frwe[i] = 2'd0;
      freg[i] = 4'hE;
      fres[i] = 16'h0;
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] addr,
                      input logic fl, input logic er);
    out_t dec;
    logic [3:0] s1, s2;
    logic exp_ready;
    in_valid = v; in_instr = ins; in_addr = addr; flush = fl; ex_ready = er;
    rd1 = 16'($urandom); rd2 = 16'($urandom);
    #2;
    m_decode(ins, addr, dec, s1, s2);
    exp_ready = !fl && !(m_hazard(s1) || m_hazard(s2)) && (er || !exp_valid);
    chk("in_ready", in_ready, exp_ready);
    chk("rf_raddr1", raddr1, s1);
    chk("rf_raddr2", raddr2, s2);
    @(posedge clk); #1;
    if (fl) exp_valid = 1'b0;
    else if (v && exp_ready) begin exp_o = dec; exp_valid = 1'b1; end
    else if (er) exp_valid = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [15:0] ins;
    logic [4:0] ops [7] = '{5'd13, 5'd9, 5'd6, 5'd19, 5'd27, 5'd2, 5'd6};
    clear_fwd();
    exp_valid = 1'b0;
    exp_o = '0;
    #12;
    check_reset("rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    step(1, 16'h6905, 16'h0000, 0, 1);
    chk("li_op1", out_op1, 16'h0005);
    chk("li_wreg", out_wreg_addr, 4'h1);
    frwe[0] = 2'd3; freg[0] = 4'h1; fres[0] = 16'h0005;
    step(1, 16'h4903, 16'h0002, 0, 1);
`ifdef ID_BYPASS_EN
    chk("addiu_fwd_valid", out_valid, 1);
    chk("addiu_fwd_op1", out_op1, 16'h0005);
    chk("addiu_fwd_op2", out_op2, 16'h0003);
`else
    chk("addiu_nobyp_bubble", out_valid, 0);
    clear_fwd();
    step(1, 16'h4903, 16'h0002, 0, 1);
    chk("addiu_nobyp_op1", out_op1, rd1);
`endif

    clear_fwd();
    step(1, 16'h9940, 16'h0004, 0, 1);
    chk("lw_rwe", out_rwe, 2'd1);
    chk("lw_wreg", out_wreg_addr, 4'h2);
    frwe[0] = 2'd1; freg[0] = 4'h2;
    step(1, 16'h4A01, 16'h0006, 0, 1);
    chk("loaduse_bubble", out_valid, 0);
    frwe[0] = 2'd0; frwe[1] = 2'd3; freg[1] = 4'h2; fres[1] = 16'h1234;
    step(1, 16'h4A01, 16'h0006, 0, 1);
`ifdef ID_BYPASS_EN
    chk("loaduse_op1", out_op1, 16'h1234);
`else
    chk("loaduse_still_stalled", out_valid, 0);
    clear_fwd();
    step(1, 16'h4A01, 16'h0006, 0, 1);
    chk("loaduse_op1", out_op1, rd1);
`endif

    frwe[0] = 2'd3; freg[0] = 4'h1; fres[0] = 16'h0011;
    frwe[1] = 2'd3; freg[1] = 4'h1; fres[1] = 16'h0022;
    step(1, 16'h4903, 16'h0008, 0, 1);
`ifdef ID_BYPASS_EN
    chk("prio_op1", out_op1, 16'h0011);
`else
    chk("prio_nobyp_bubble", out_valid, 0);
`endif

    clear_fwd();
    step(1, 16'h1004, 16'h0010, 0, 1);
    chk("b_branch", out_branch, 1);
    chk("b_new_pc", out_new_pc, 16'h0014);
    step(1, 16'h17FF, 16'h0010, 0, 1);
    chk("b_neg_new_pc", out_new_pc, 16'h000F);
    for (int k = 0; k < 3; k++) begin
      step(1, 16'h6905, 16'h0020, 0, 0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_branch", out_branch, 1);
      chk("hold_new_pc", out_new_pc, 16'h000F);
    end
    step(1, 16'h6905, 16'h0020, 1, 0);
    chk("flush_valid", out_valid, 0);

    step(1, 16'h9940, 16'h0030, 0, 1);
    frwe[0] = 2'd1; freg[0] = 4'h2;
    step(1, 16'h4A01, 16'h0032, 0, 0);
    chk("stall_hold_valid", out_valid, 1);
    #2; rst = 1'b1; #1;
    check_reset("midrst");
    rst = 1'b0;
    clear_fwd();
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    exp_valid = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 2; i++) begin
        frwe[i] = 2'($urandom);
        freg[i] = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
        fres[i] = 16'($urandom);
      end
      ins = 16'($urandom);
      if ($urandom_range(0, 7) != 0) ins[15:11] = ops[$urandom_range(0, 6)];
      if (ins[15:11] == 5'd6 && $urandom_range(0, 1) == 1) ins[1:0] = 2'b00;
      ins[10:8] = 3'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, ins, 16'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
